obi_cmd_mgr: RTL and testbench

OBI manager that converts a simple valid/ready command stream into OBI A-phase requests and returns R-phase responses on a valid/ready response stream, in order. Sits between SoC-side masters without native OBI (debug bridge, boot sequencer, test controllers) and the crossbar, talking to OBI subordinates such as the SoC control registers. Bounds outstanding transactions so every R-phase beat has guaranteed buffer space, because OBI has no rready.

---
 rtl/obi_cmd_mgr.sv | 225 ++++++++++++++++++++++
 tb/tb_obi_cmd_mgr.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_cmd_mgr.sv
// obi_cmd_mgr: turns a valid/ready command stream into OBI A-phase requests
// and returns the R-phase beats, in order, on a valid/ready response stream.
// Outstanding transactions are bounded by MaxTrans, so every R-phase beat
// always finds a free slot in the response FIFO (OBI has no rready).
// Optional R-phase timeout: define OBI_CMD_MGR_TIMEOUT_EN.

package obi_cmd_mgr_pkg;
    localparam int unsigned AidWidth = 3;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         wdata;
        logic [AidWidth-1:0] aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0]         rdata;
        logic                err;
        logic [AidWidth-1:0] rid;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;
endpackage

module obi_cmd_mgr #(
    parameter type         obi_req_t     = obi_cmd_mgr_pkg::obi_req_t,
    parameter type         obi_rsp_t     = obi_cmd_mgr_pkg::obi_rsp_t,
    parameter int unsigned MaxTrans      = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    input  logic        clear_i,
    output logic        busy_o,
    output obi_req_t    obi_req_o,
    input  obi_rsp_t    obi_rsp_i
);
    import obi_cmd_mgr_pkg::rsp_entry_t;
    import obi_cmd_mgr_pkg::state_t;
    import obi_cmd_mgr_pkg::RUN;
    import obi_cmd_mgr_pkg::FAULT;

    localparam int unsigned IdW  = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned AidW = obi_cmd_mgr_pkg::AidWidth;

    typedef logic [IdW-1:0]  id_t;
    typedef logic [CntW-1:0] cnt_t;

    state_t     r_state, w_state_nxt;
    cnt_t       r_inflight, r_pending;
    id_t        r_issue_id, r_expect_id, r_wr_ptr, r_rd_ptr;
    rsp_entry_t r_fifo [MaxTrans];
    logic       r_we_shadow [MaxTrans];

    logic       w_run, w_credit, w_accept, w_pop, w_rvalid_ok, w_timeout, w_clear_go;
    cnt_t       w_fifo_cnt, w_push_n;
    rsp_entry_t w_push_entry, w_head;

    // Pointer/ID arithmetic modulo MaxTrans (also correct for MaxTrans == 1).
    function automatic id_t ptr_add(input id_t ptr, input int unsigned n);
        int unsigned sum;
        sum = 32'(ptr) + n;
        return id_t'(sum % MaxTrans);
    endfunction

    assign w_run       = (r_state == RUN);
    assign w_credit    = (r_inflight < cnt_t'(MaxTrans));
    assign cmd_ready_o = obi_req_o.req & obi_rsp_i.gnt;
    assign w_accept    = cmd_ready_o;
    assign w_rvalid_ok = obi_rsp_i.rvalid & (r_pending != '0);
    assign w_fifo_cnt  = r_inflight - r_pending;
    assign w_pop       = rsp_valid_o & rsp_ready_i;
    assign w_clear_go  = (r_state == FAULT) & clear_i & (r_pending == '0);

    assign w_head        = r_fifo[r_rd_ptr];
    assign rsp_valid_o   = (w_fifo_cnt != '0);
    assign rsp_rdata_o   = rsp_valid_o ? w_head.rdata : '0;
    assign rsp_err_o     = rsp_valid_o & w_head.err;
    assign rsp_timeout_o = rsp_valid_o & w_head.timeout;
    assign busy_o        = (r_inflight != '0);

    // A-phase: request fields pass straight through from the command.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        obi_req_o         = '0;
        obi_req_o.req     = cmd_valid_i & w_credit & w_run;
        obi_req_o.a.addr  = cmd_addr_i;
        obi_req_o.a.we    = cmd_we_i;
        obi_req_o.a.be    = cmd_be_i;
        obi_req_o.a.wdata = cmd_we_i ? cmd_wdata_i : '0;
        obi_req_o.a.aid   = AidW'(r_issue_id);
    end

`ifdef OBI_CMD_MGR_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
    logic [ToW-1:0] r_to_cnt;

    // Fires on the TimeoutCycles-th consecutive cycle waiting for an R beat.
    assign w_timeout = w_run & (r_pending != '0) & ~obi_rsp_i.rvalid &
                       (r_to_cnt == ToW'(TimeoutCycles - 1));

    // R-phase watchdog: counts idle cycles while transactions are pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
        end else if (obi_rsp_i.rvalid || (r_pending == '0) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Response FIFO push: one real beat, or one synthesized beat per pending
    // transaction (including one accepted this very cycle) on timeout.
    always_comb begin
        w_push_n     = '0;
        w_push_entry = '0;
        if (w_timeout) begin
            w_push_n             = r_pending + cnt_t'(w_accept);
            w_push_entry.rdata   = 32'hDEAD_BEEF;
            w_push_entry.err     = 1'b1;
            w_push_entry.timeout = 1'b1;
        end else if (w_rvalid_ok) begin
            w_push_n           = cnt_t'(1);
            w_push_entry.rdata = r_we_shadow[r_expect_id] ? '0 : obi_rsp_i.r.rdata;
            w_push_entry.err   = obi_rsp_i.r.err | (obi_rsp_i.r.rid != AidW'(r_expect_id));
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    // Next state: timeout traps into FAULT; clear leaves it once drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:   if (w_timeout)  w_state_nxt = FAULT;
            FAULT: if (w_clear_go) w_state_nxt = RUN;
        endcase
    end

    // Transaction bookkeeping: counters, IDs and FIFO pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight  <= '0;
            r_pending   <= '0;
            r_issue_id  <= '0;
            r_expect_id <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_inflight <= r_inflight + cnt_t'(w_accept) - cnt_t'(w_pop);
            if (w_timeout) r_pending <= '0;
            else           r_pending <= r_pending + cnt_t'(w_accept) - cnt_t'(w_rvalid_ok);
            if (w_clear_go) begin
                r_issue_id  <= '0;
                r_expect_id <= '0;
            end else begin
                if (w_accept)    r_issue_id  <= ptr_add(r_issue_id, 1);
                if (w_rvalid_ok) r_expect_id <= ptr_add(r_expect_id, 1);
            end
            r_wr_ptr <= ptr_add(r_wr_ptr, 32'(w_push_n));
            if (w_pop) r_rd_ptr <= ptr_add(r_rd_ptr, 1);
        end
    end

    // FIFO storage and per-ID write flag.
    // NOTE: storage arrays carry no reset; pointers and counts qualify every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(MaxTrans); i++) begin
            if (i < int'(w_push_n)) r_fifo[ptr_add(r_wr_ptr, unsigned'(i))] <= w_push_entry;
        end
        if (w_accept) r_we_shadow[r_issue_id] <= cmd_we_i;
    end

    // An R beat must never find the FIFO full.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (32'(w_fifo_cnt) + 32'(w_push_n)) <= MaxTrans);

    // Legal configuration.
    a_params: assert property (@(posedge clk_i)
        (MaxTrans inside {1, 2, 4, 8}) && (TimeoutCycles >= 1));

endmodule

// File: tb/tb_obi_cmd_mgr.sv
// Self-checking bench for obi_cmd_mgr: a queue-based model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_obi_cmd_mgr;
    localparam int unsigned MT = 2;
    localparam int unsigned TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i;
    logic [3:0]  cmd_be_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o, rsp_timeout_o, clear_i, busy_o;
    obi_cmd_mgr_pkg::obi_req_t obi_req;
    obi_cmd_mgr_pkg::obi_rsp_t obi_rsp;

    obi_cmd_mgr #(.MaxTrans(MT), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .clear_i(clear_i),
        .busy_o(busy_o), .obi_req_o(obi_req), .obi_rsp_i(obi_rsp)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic we; int unsigned aid; } pend_t;
    typedef struct { logic [31:0] rdata; logic err; logic to; } exp_t;

    pend_t       q_pend[$];   // accepted, no R beat yet
    exp_t        q_rsp[$];    // responses waiting to be popped
    int unsigned m_issue;
    bit          m_fault;
    int unsigned m_to;

    bit          exp_req, accept, pop, timed_out;
    int          pend_n;
    pend_t       p;
    exp_t        e;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q_pend.delete();
            q_rsp.delete();
            m_issue = 0;
            m_fault = 0;
            m_to    = 0;
            check("rst_rsp_valid", rsp_valid_o, 0);
            check("rst_busy", busy_o, 0);
        end else begin
            pend_n  = q_pend.size();
            exp_req = cmd_valid_i && ((q_pend.size() + q_rsp.size()) < MT) && !m_fault;
            check("req", obi_req.req, exp_req);
            if (exp_req) begin
                check("req_addr", obi_req.a.addr, cmd_addr_i);
                check("req_we", obi_req.a.we, cmd_we_i);
                check("req_be", obi_req.a.be, cmd_be_i);
                check("req_wdata", obi_req.a.wdata, cmd_we_i ? cmd_wdata_i : 32'h0);
                check("req_aid", 32'(obi_req.a.aid), m_issue);
            end
            check("cmd_ready", cmd_ready_o, exp_req && obi_rsp.gnt);
            check("rsp_valid", rsp_valid_o, q_rsp.size() != 0);
            if (q_rsp.size() != 0) begin
                check("rsp_rdata", rsp_rdata_o, q_rsp[0].rdata);
                check("rsp_err", rsp_err_o, q_rsp[0].err);
                check("rsp_timeout", rsp_timeout_o, q_rsp[0].to);
            end else begin
                check("rsp_err_idle", rsp_err_o, 0);
                check("rsp_timeout_idle", rsp_timeout_o, 0);
            end
            check("busy", busy_o, (q_pend.size() + q_rsp.size()) != 0);

            // events of this cycle, applied as of the coming edge
            accept    = exp_req && obi_rsp.gnt;
            pop       = (q_rsp.size() != 0) && rsp_ready_i;
            timed_out = 0;
`ifdef OBI_CMD_MGR_TIMEOUT_EN
            if (!m_fault && pend_n != 0 && !obi_rsp.rvalid) begin
                m_to++;
                if (m_to == TO) timed_out = 1;
            end else begin
                m_to = 0;
            end
            if (m_fault && clear_i && pend_n == 0) begin
                m_fault = 0;
                m_issue = 0;
            end
`endif
            if (pop) void'(q_rsp.pop_front());
            if (obi_rsp.rvalid && pend_n != 0) begin
                p       = q_pend.pop_front();
                e.rdata = p.we ? 32'h0 : obi_rsp.r.rdata;
                e.err   = obi_rsp.r.err || (32'(obi_rsp.r.rid) != p.aid);
                e.to    = 0;
                q_rsp.push_back(e);
            end
            if (accept) begin
                p.we  = cmd_we_i;
                p.aid = m_issue;
                q_pend.push_back(p);
                m_issue = (m_issue + 1) % MT;
            end
            if (timed_out) begin
                for (int i = 0; i < q_pend.size(); i++) begin
                    e.rdata = 32'hDEAD_BEEF;
                    e.err   = 1;
                    e.to    = 1;
                    q_rsp.push_back(e);
                end
                q_pend.delete();
                m_fault = 1;
                m_to    = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        cmd_valid_i = v;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_be_i    = be;
    endtask

    task automatic set_r(input logic rv, input logic [31:0] rdata, input logic err,
                         input logic [2:0] rid);
        obi_rsp.rvalid  = rv;
        obi_rsp.r.rdata = rdata;
        obi_rsp.r.err   = err;
        obi_rsp.r.rid   = rid;
    endtask

    int k;

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        rsp_ready_i = 1'b1;
        obi_rsp.gnt = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        set_r(0, 0, 0, 0);
        cyc();
        cyc();
        rst_ni = 1'b1;
        #1;
        check("reset_req", obi_req.req, 0);
        check("reset_cmd_ready", cmd_ready_o, 0);
        check("reset_rsp_valid", rsp_valid_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_err", rsp_err_o, 0);
        check("reset_timeout", rsp_timeout_o, 0);

        // write, immediate gnt, rvalid next cycle
        set_cmd(1, 1, 32'h0300_0000, 32'h0000_00AA, 4'hF);
        obi_rsp.gnt = 1;
        #1;
        check("t1_req", obi_req.req, 1);
        check("t1_ready", cmd_ready_o, 1);
        check("t1_wdata", obi_req.a.wdata, 32'h0000_00AA);
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        set_r(1, 32'h5555_5555, 0, 0);
        #1;
        check("t1_no_rsp_yet", rsp_valid_o, 0);
        check("t1_busy", busy_o, 1);
        cyc();
        set_r(0, 0, 0, 0);
        #1;
        check("t1_rsp_valid", rsp_valid_o, 1);
        check("t1_rsp_rdata", rsp_rdata_o, 32'h0);
        check("t1_rsp_err", rsp_err_o, 0);
        cyc();
        #1;
        check("t1_drained", rsp_valid_o, 0);

        // read with gnt delayed 3 cycles
        set_cmd(1, 0, 32'h0300_0004, 32'hFFFF_FFFF, 4'hF);
        obi_rsp.gnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_hold_req", obi_req.req, 1);
            check("t2_hold_addr", obi_req.a.addr, 32'h0300_0004);
            check("t2_hold_ready", cmd_ready_o, 0);
            cyc();
        end
        obi_rsp.gnt = 1;
        #1;
        check("t2_ready_cycle4", cmd_ready_o, 1);
        check("t2_read_wdata", obi_req.a.wdata, 32'h0);
        check("t2_aid", 32'(obi_req.a.aid), 1);
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        set_r(1, 32'h1234_5678, 0, 1);
        cyc();
        set_r(0, 0, 0, 0);
        #1;
        check("t2_rdata", rsp_rdata_o, 32'h1234_5678);
        check("t2_err", rsp_err_o, 0);
        cyc();

        // credit limit with response back-pressure
        rsp_ready_i = 0;
        set_cmd(1, 0, 32'h0000_0010, 0, 4'hF);
        obi_rsp.gnt = 1;
        cyc();
        set_cmd(1, 0, 32'h0000_0014, 0, 4'hF);
        set_r(1, 32'h1111_0000, 0, 0);
        cyc();
        set_cmd(1, 0, 32'h0000_0018, 0, 4'hF);
        set_r(1, 32'h2222_0000, 0, 1);
        #1;
        check("t3_no_credit_req", obi_req.req, 0);
        check("t3_no_credit_ready", cmd_ready_o, 0);
        cyc();
        set_r(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t3_blocked", cmd_ready_o, 0);
            check("t3_head", rsp_rdata_o, 32'h1111_0000);
            cyc();
        end
        rsp_ready_i = 1;
        #1;
        check("t3_pop_cycle_ready", cmd_ready_o, 0);
        cyc();
        rsp_ready_i = 0;
        #1;
        check("t3_third_accept", cmd_ready_o, 1);
        check("t3_head2", rsp_rdata_o, 32'h2222_0000);
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        set_r(1, 32'h3333_0000, 0, 0);
        cyc();
        set_r(0, 0, 0, 0);
        rsp_ready_i = 1;
        #1;
        check("t3_order1", rsp_rdata_o, 32'h2222_0000);
        cyc();
        #1;
        check("t3_order2", rsp_rdata_o, 32'h3333_0000);
        cyc();
        #1;
        check("t3_empty", rsp_valid_o, 0);

        // OBI err, then a wrong rid
        set_cmd(1, 0, 32'h0300_0FFC, 0, 4'hF);
        obi_rsp.gnt = 1;
        #1;
        check("t4_aid", 32'(obi_req.a.aid), 1);
        cyc();
        set_cmd(1, 0, 32'h0300_0008, 0, 4'hF);
        set_r(1, 32'hBADC_AB1E, 1, 1);
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        set_r(1, 32'h0BAD_0001, 0, 1);
        #1;
        check("t4_err", rsp_err_o, 1);
        check("t4_err_rdata", rsp_rdata_o, 32'hBADC_AB1E);
        cyc();
        set_r(0, 0, 0, 0);
        #1;
        check("t4_rid_err", rsp_err_o, 1);
        check("t4_rid_rdata", rsp_rdata_o, 32'h0BAD_0001);
        cyc();
        #1;
        check("t4_empty", rsp_valid_o, 0);

`ifdef OBI_CMD_MGR_TIMEOUT_EN
        // R-phase timeout with two pending, FAULT, late rvalid, clear
        rsp_ready_i = 0;
        set_cmd(1, 0, 32'h0000_0020, 0, 4'hF);
        obi_rsp.gnt = 1;
        cyc();
        set_cmd(1, 0, 32'h0000_0024, 0, 4'hF);
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        for (k = 0; k < 40; k++) begin
            #1;
            if (rsp_valid_o) break;
            cyc();
        end
        check("t5_timeout_seen", rsp_valid_o, 1);
        check("t5_timeout_latency", k, 15);
        check("t5_to_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        check("t5_to_flag", rsp_timeout_o, 1);
        check("t5_to_err", rsp_err_o, 1);
        rsp_ready_i = 1;
        cyc();
        #1;
        check("t5_to_rdata2", rsp_rdata_o, 32'hDEAD_BEEF);
        check("t5_to_flag2", rsp_timeout_o, 1);
        cyc();
        rsp_ready_i = 0;
        #1;
        check("t5_drained", rsp_valid_o, 0);
        check("t5_not_busy", busy_o, 0);
        set_cmd(1, 0, 32'h0000_0028, 0, 4'hF);
        obi_rsp.gnt = 1;
        set_r(1, 32'h7777_7777, 0, 1);
        #1;
        check("t5_fault_no_req", obi_req.req, 0);
        cyc();
        set_r(0, 0, 0, 0);
        #1;
        check("t5_late_dropped", rsp_valid_o, 0);
        clear_i = 1;
        #1;
        check("t5_clear_cycle_no_req", obi_req.req, 0);
        cyc();
        clear_i = 0;
        #1;
        check("t5_after_clear_ready", cmd_ready_o, 1);
        check("t5_after_clear_aid", 32'(obi_req.a.aid), 0);
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        set_r(1, 32'hCAFE_0001, 0, 0);
        cyc();
        set_r(0, 0, 0, 0);
        rsp_ready_i = 1;
        #1;
        check("t5_resume_rdata", rsp_rdata_o, 32'hCAFE_0001);
        check("t5_resume_to", rsp_timeout_o, 0);
        cyc();
`endif

        // reset with one pending, late rvalid afterwards
        set_cmd(1, 0, 32'h0000_0030, 0, 4'hF);
        obi_rsp.gnt = 1;
        cyc();
        set_cmd(0, 0, 0, 0, 0);
        obi_rsp.gnt = 0;
        #1;
        check("t6_busy_before", busy_o, 1);
        rst_ni = 0;
        cyc();
        rst_ni = 1;
        set_r(1, 32'h9999_9999, 0, 0);
        cyc();
        set_r(0, 0, 0, 0);
        #1;
        check("t6_late_dropped", rsp_valid_o, 0);
        check("t6_busy_after", busy_o, 0);
        cyc();
        #1;
        check("t6_still_idle", rsp_valid_o, 0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
